debug_cpu_control: RTL and testbench

- Run-control stage downstream of the debugger's value bus. Consumes value-id read/write transactions and gates the 6502 core through a clock-enable and a reset line.
- Provides run, halt, N-cycle step, N-instruction step, CPU reset pulse, a 32-bit cycle counter and an optional address breakpoint.
- Lets the host (over SPI) single-step and observe the CPU.

---
 rtl/debug_cpu_control.sv | 260 ++++++++++++++++++++++++++
 tb/tb_debug_cpu_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cpu_control.sv
// rtl/debug_cpu_control.sv - run-control stage gating a 6502 core from debugger value-bus transactions
//
// Ports:
//   i_clk, i_reset_n             system clock, asynchronous active-low reset
//   i_value_id/rw/en/data        value-bus request (id, 1=read/0=write, strobe, write data)
//   o_value_data                 registered read data, held until the next in-range read
//   i_cpu_sync, i_cpu_address    6502 opcode-fetch flag and address bus
//   o_cpu_ce                     one-cycle CPU clock-enable pulse
//   o_cpu_reset_n                active-low reset to the 6502
//   o_halted                     registered HALTED indication
//
// Optional feature macro: DEBUG_CPU_BREAKPOINT_EN (address breakpoint on opcode fetch).

module debug_cpu_control #(
    parameter logic [15:0] ID_BASE         = 16'h0000,
    parameter int          CLK_DIV_DEFAULT = 20,
    parameter int          RESET_CYCLES    = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_value_id,
    input  logic        i_value_rw,
    input  logic        i_value_en,
    input  logic [15:0] i_value_data,
    output logic [15:0] o_value_data,
    input  logic        i_cpu_sync,
    input  logic [15:0] i_cpu_address,
    output logic        o_cpu_ce,
    output logic        o_cpu_reset_n,
    output logic        o_halted
);

    typedef enum logic [2:0] {
        ST_HALTED    = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_STEP_CYC  = 3'd2,
        ST_STEP_INS  = 3'd3,
        ST_RESETTING = 3'd4
    } state_t;

    localparam logic [15:0] CMD_RUN       = 16'd1;
    localparam logic [15:0] CMD_HALT      = 16'd2;
    localparam logic [15:0] CMD_STEP_CYC  = 16'd3;
    localparam logic [15:0] CMD_STEP_INS  = 16'd4;
    localparam logic [15:0] CMD_RESET     = 16'd5;
    localparam logic [15:0] RST_LAST      = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] DIV_DEFAULT   = 16'(CLK_DIV_DEFAULT);

    state_t      state, state_nxt;
    logic [15:0] clk_div;
    logic [15:0] div_act;       // divider value in use; picks up clk_div only at a wrap or while halted
    logic [15:0] div_cnt;
    logic [15:0] div_top;
    logic [31:0] cycles;
    logic [15:0] step_count;
    logic [15:0] remaining;
    logic [15:0] reset_cnt;
    logic        bp_hit;
    logic        cpu_reset_n;
    logic        halted;
    logic [15:0] value_data;
    logic        ce;

    logic [15:0] offset;
    logic        in_range, wr, rd, cmd_wr;
    logic [15:0] rd_mux;
    logic        bp_now;

    // FSM side effects decoded alongside next state
    logic        take_run, take_step, reset_start, reset_done, rem_dec, bp_set;

`ifdef DEBUG_CPU_BREAKPOINT_EN
    logic [15:0] bp_addr;
    logic        bp_en;
`endif

    assign offset   = i_value_id - ID_BASE;
    assign in_range = (offset[15:3] == 13'd0);
    assign wr       = i_value_en & ~i_value_rw & in_range;
    assign rd       = i_value_en &  i_value_rw & in_range;
    assign cmd_wr   = wr & (offset[2:0] == 3'd1);

    // A divider value of 0 behaves like 1 (pulse every cycle)
    assign div_top  = (div_act == 16'd0) ? 16'd0 : div_act - 16'd1;
    assign ce       = (state != ST_HALTED) && (div_cnt == div_top);

`ifdef DEBUG_CPU_BREAKPOINT_EN
    assign bp_now = ce & bp_en & i_cpu_sync & (i_cpu_address == bp_addr) &
                    ((state == ST_RUNNING) || (state == ST_STEP_CYC) || (state == ST_STEP_INS));
`else
    logic unused_bp_addr;
    assign unused_bp_addr = ^i_cpu_address;
    assign bp_now = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_HALTED;
        end else begin
            state <= state_nxt;
        end
    end

    // Accepted commands take priority over every internal transition;
    // RUN/STEP outside HALTED are not accepted, so they never block one.
    always_comb begin
        state_nxt   = state;
        take_run    = 1'b0;
        take_step   = 1'b0;
        reset_start = 1'b0;
        reset_done  = 1'b0;
        rem_dec     = 1'b0;
        bp_set      = 1'b0;
        if (cmd_wr && i_value_data == CMD_RUN && state == ST_HALTED) begin
            state_nxt = ST_RUNNING;
            take_run  = 1'b1;
        end else if (cmd_wr && (i_value_data == CMD_STEP_CYC || i_value_data == CMD_STEP_INS) &&
                     state == ST_HALTED && step_count != 16'd0) begin
            state_nxt = (i_value_data == CMD_STEP_CYC) ? ST_STEP_CYC : ST_STEP_INS;
            take_step = 1'b1;
        end else if (cmd_wr && i_value_data == CMD_HALT) begin
            state_nxt = ST_HALTED;
        end else if (cmd_wr && i_value_data == CMD_RESET) begin
            state_nxt   = ST_RESETTING;
            reset_start = 1'b1;
        end else begin
            case (state)
                ST_RUNNING: begin
                    if (bp_now) begin
                        state_nxt = ST_HALTED;
                        bp_set    = 1'b1;
                    end
                end
                ST_STEP_CYC: begin
                    if (bp_now) begin
                        state_nxt = ST_HALTED;
                        bp_set    = 1'b1;
                    end else if (ce) begin
                        rem_dec = 1'b1;
                        if (remaining == 16'd1) state_nxt = ST_HALTED;
                    end
                end
                ST_STEP_INS: begin
                    if (bp_now) begin
                        state_nxt = ST_HALTED;
                        bp_set    = 1'b1;
                    end else if (ce && i_cpu_sync) begin
                        rem_dec = 1'b1;
                        if (remaining == 16'd1) state_nxt = ST_HALTED;
                    end
                end
                ST_RESETTING: begin
                    if (ce && reset_cnt == RST_LAST) begin
                        state_nxt  = ST_HALTED;
                        reset_done = 1'b1;
                    end
                end
                default: state_nxt = ST_HALTED;
            endcase
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (offset[2:0])
            3'd0: rd_mux = {11'b0, cpu_reset_n, bp_hit, state};
            3'd2: rd_mux = step_count;
            3'd3: rd_mux = cycles[15:0];
            3'd4: rd_mux = cycles[31:16];
`ifdef DEBUG_CPU_BREAKPOINT_EN
            3'd5: rd_mux = bp_addr;
            3'd6: rd_mux = {15'b0, bp_en};
`endif
            3'd7: rd_mux = clk_div;
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            clk_div     <= DIV_DEFAULT;
            div_act     <= DIV_DEFAULT;
            div_cnt     <= 16'd0;
            cycles      <= 32'd0;
            step_count  <= 16'd0;
            remaining   <= 16'd0;
            reset_cnt   <= 16'd0;
            bp_hit      <= 1'b0;
            cpu_reset_n <= 1'b1;
            halted      <= 1'b1;
            value_data  <= 16'h0000;
        end else begin
            halted      <= (state_nxt == ST_HALTED);
            cpu_reset_n <= (state_nxt != ST_RESETTING);

            if (state_nxt == ST_HALTED || ce) begin
                div_cnt <= 16'd0;
            end else if (state != ST_HALTED) begin
                div_cnt <= div_cnt + 16'd1;
            end
            if (state == ST_HALTED || ce) begin
                div_act <= clk_div;
            end

            if (reset_done) begin
                cycles <= 32'd0;
            end else if (ce && cpu_reset_n) begin
                cycles <= cycles + 32'd1;
            end

            if (reset_start) begin
                reset_cnt <= 16'd0;
            end else if (state == ST_RESETTING && ce) begin
                reset_cnt <= reset_cnt + 16'd1;
            end

            if (take_step) begin
                remaining <= step_count;
            end else if (rem_dec) begin
                remaining <= remaining - 16'd1;
            end

            if (take_run || take_step) begin
                bp_hit <= 1'b0;
            end else if (bp_set) begin
                bp_hit <= 1'b1;
            end

            if (wr) begin
                case (offset[2:0])
                    3'd2: step_count <= i_value_data;
                    3'd7: clk_div    <= i_value_data;
                    default: ;
                endcase
            end

            if (rd) begin
                value_data <= rd_mux;
            end
        end
    end

`ifdef DEBUG_CPU_BREAKPOINT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bp_addr <= 16'h0000;
            bp_en   <= 1'b0;
        end else if (wr) begin
            if (offset[2:0] == 3'd5) bp_addr <= i_value_data;
            if (offset[2:0] == 3'd6) bp_en   <= i_value_data[0];
        end
    end
`endif

    assign o_cpu_ce      = ce;
    assign o_cpu_reset_n = cpu_reset_n;
    assign o_halted      = halted;
    assign o_value_data  = value_data;

endmodule

// File: tb/tb_debug_cpu_control.sv
// tb/tb_debug_cpu_control.sv - directed self-checking bench for debug_cpu_control

module tb_debug_cpu_control;

    logic        clk;
    logic        reset_n;
    logic [15:0] value_id;
    logic        value_rw;
    logic        value_en;
    logic [15:0] value_wdata;
    logic [15:0] value_rdata;
    logic        cpu_sync;
    logic [15:0] cpu_address;
    logic        cpu_ce;
    logic        cpu_reset_n;
    logic        halted;

    int total;
    int bad;
    int cnt;
    int first;
    int last;
    int gap_bad;
    logic [15:0] d;

    debug_cpu_control dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_value_id    (value_id),
        .i_value_rw    (value_rw),
        .i_value_en    (value_en),
        .i_value_data  (value_wdata),
        .o_value_data  (value_rdata),
        .i_cpu_sync    (cpu_sync),
        .i_cpu_address (cpu_address),
        .o_cpu_ce      (cpu_ce),
        .o_cpu_reset_n (cpu_reset_n),
        .o_halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr_val(input logic [15:0] id, input logic [15:0] data);
        @(negedge clk);
        value_id    = id;
        value_rw    = 1'b0;
        value_wdata = data;
        value_en    = 1'b1;
        @(negedge clk);
        value_en    = 1'b0;
    endtask

    task automatic rd_val(input logic [15:0] id, output logic [15:0] data);
        @(negedge clk);
        value_id = id;
        value_rw = 1'b1;
        value_en = 1'b1;
        @(negedge clk);
        value_en = 1'b0;
        data     = value_rdata;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        value_id    = 16'h0;
        value_rw    = 1'b0;
        value_en    = 1'b0;
        value_wdata = 16'h0;
        cpu_sync    = 1'b0;
        cpu_address = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_ce", {31'b0, cpu_ce}, 32'd0);
        check("rst_cpu_reset_n", {31'b0, cpu_reset_n}, 32'd1);
        check("rst_halted", {31'b0, halted}, 32'd1);
        check("rst_value_data", {16'b0, value_rdata}, 32'd0);
        reset_n = 1'b1;

        rd_val(16'd0, d); check("status_reset", {16'b0, d}, 32'h0010);
        rd_val(16'd7, d); check("clk_div_reset", {16'b0, d}, 32'd20);
        wr_val(16'd8, 16'd3);
        rd_val(16'd7, d); check("out_of_range_write", {16'b0, d}, 32'd20);
        rd_val(16'h0100, d); check("out_of_range_read_hold", {16'b0, d}, 32'd20);
        wr_val(16'd3, 16'hABCD);
        rd_val(16'd3, d); check("ro_write_ignored", {16'b0, d}, 32'd0);

        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cpu_ce) cnt++;
        end
        check("halted_ce_silent", cnt, 0);

        // Cycle step: 3 pulses, 4 cycles apart, first 4 cycles after the command
        wr_val(16'd7, 16'd4);
        wr_val(16'd2, 16'd3);
        wr_val(16'd1, 16'd3);
        cnt = 0; first = -1; last = -1; gap_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (cpu_ce) begin
                if (cnt == 0) first = i;
                else if (i - last != 4) gap_bad++;
                last = i;
                cnt++;
            end
        end
        check("stepc_count", cnt, 3);
        check("stepc_first", first, 3);
        check("stepc_gaps", gap_bad, 0);
        rd_val(16'd0, d); check("stepc_status", {16'b0, d}, 32'h0010);
        rd_val(16'd3, d); check("stepc_cycles_lo", {16'b0, d}, 32'd3);

        // Instruction step: sync on every 3rd ce, 2 instructions -> 6 pulses
        wr_val(16'd7, 16'd1);
        wr_val(16'd2, 16'd2);
        wr_val(16'd1, 16'd4);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (cpu_ce) begin
                cnt++;
                cpu_sync = (cnt % 3 == 0);
            end else begin
                cpu_sync = 1'b0;
            end
        end
        cpu_sync = 1'b0;
        check("stepi_count", cnt, 6);
        check("stepi_halted", {31'b0, halted}, 32'd1);
        rd_val(16'd3, d); check("stepi_cycles_lo", {16'b0, d}, 32'd9);

        // STEP with count 0 and an unknown command code do nothing
        wr_val(16'd2, 16'd0);
        wr_val(16'd1, 16'd3);
        wr_val(16'd1, 16'd7);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_ce) cnt++;
        end
        check("step0_no_ce", cnt, 0);
        check("step0_halted", {31'b0, halted}, 32'd1);

        // CPU reset: held low for 8 pulses at CLK_DIV=2, counter cleared
        wr_val(16'd7, 16'd2);
        wr_val(16'd1, 16'd5);
        check("reset_asserted", {31'b0, cpu_reset_n}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (cpu_ce && !cpu_reset_n) cnt++;
        end
        check("reset_pulses", cnt, 8);
        rd_val(16'd0, d); check("reset_status", {16'b0, d}, 32'h0010);
        rd_val(16'd3, d); check("reset_cycles_lo", {16'b0, d}, 32'd0);

        // Free run at CLK_DIV=20 for ~100 cycles -> 5 pulses
        wr_val(16'd7, 16'd20);
        wr_val(16'd1, 16'd1);
        repeat (100) @(negedge clk);
        rd_val(16'd0, d); check("run_status", {16'b0, d}, 32'h0011);
        wr_val(16'd1, 16'd2);
        check("run_halted", {31'b0, halted}, 32'd1);
        rd_val(16'd3, d); check("run_cycles_lo", {16'b0, d}, 32'd5);
        rd_val(16'd4, d); check("run_cycles_hi", {16'b0, d}, 32'd0);

        // HALT during reset releases immediately and keeps the cycle count
        wr_val(16'd1, 16'd5);
        repeat (5) @(negedge clk);
        check("midreset_low", {31'b0, cpu_reset_n}, 32'd0);
        wr_val(16'd1, 16'd2);
        check("midreset_release", {31'b0, cpu_reset_n}, 32'd1);
        check("midreset_halted", {31'b0, halted}, 32'd1);
        rd_val(16'd3, d); check("midreset_cycles_kept", {16'b0, d}, 32'd5);

`ifdef DEBUG_CPU_BREAKPOINT_EN
        wr_val(16'd7, 16'd1);
        wr_val(16'd5, 16'hC000);
        wr_val(16'd6, 16'd1);
        rd_val(16'd5, d); check("bp_addr_rd", {16'b0, d}, 32'h0000C000);
        rd_val(16'd6, d); check("bp_en_rd", {16'b0, d}, 32'd1);
        cpu_address = 16'hC000;
        cpu_sync    = 1'b1;
        wr_val(16'd1, 16'd1);
        repeat (4) @(negedge clk);
        check("bp_halted", {31'b0, halted}, 32'd1);
        rd_val(16'd0, d); check("bp_status", {16'b0, d}, 32'h0018);
        cpu_sync = 1'b0;
        wr_val(16'd1, 16'd1);
        rd_val(16'd0, d); check("bp_run_clears", {16'b0, d}, 32'h0011);
        // HALT written in the same cycle as a breakpoint hit: the command wins
        @(negedge clk);
        cpu_sync    = 1'b1;
        value_id    = 16'd1;
        value_rw    = 1'b0;
        value_wdata = 16'd2;
        value_en    = 1'b1;
        @(negedge clk);
        value_en    = 1'b0;
        cpu_sync    = 1'b0;
        rd_val(16'd0, d); check("bp_cmd_wins", {16'b0, d}, 32'h0010);
`else
        wr_val(16'd5, 16'hC000);
        wr_val(16'd6, 16'd1);
        rd_val(16'd5, d); check("nobp_addr_zero", {16'b0, d}, 32'd0);
        rd_val(16'd6, d); check("nobp_en_zero", {16'b0, d}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
